// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Phase pairs are packed as {a, b}.
package qdec_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } qdec_state_t;

  // Polarity matches the downstream counter's up_down input
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Forward Gray successor: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t gray_next(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-side and counter-side signals of the quadrature step decoder.
// The decoder uses the slave view; the driver of the encoder phases uses master.
interface quad_step_decoder_if;
  logic enc_a;
  logic enc_b;
  logic err_clr;
  logic step;
  logic up_down;
  logic err;

  modport master (
    output enc_a, enc_b, err_clr,
    input  step, up_down, err
  );

  modport slave (
    input  enc_a, enc_b, err_clr,
    output step, up_down, err
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// Synchronises the two encoder phases and debounces them as one 2-bit vector.
// Emits the filtered pair f and a one-cycle accept pulse whenever f is (re)loaded.
module quad_glitch_filter
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enc_a,
  input  logic   enc_b,
  output phase_t f,
  output logic   accept
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic [2*SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0]   valid_reg;
  phase_t                   cand_reg, cand_next;
  logic [CW-1:0]            cnt_reg, cnt_next;
  phase_t                   f_reg;
  logic                     primed_reg;
  logic                     accept_reg;
  logic                     take;
  phase_t                   s;
  logic                     s_valid;

  assign s       = sync_reg[2*SYNC_STAGES-1 -: 2];
  // The filter ignores the cleared synchroniser contents until real samples arrive
  assign s_valid = valid_reg[SYNC_STAGES-1];

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    if (s != cand_reg) begin
      cand_next = s;
      cnt_next  = CW'(1);
    end else if (cnt_reg < CW'(FILT_CYCLES)) begin
      cnt_next = cnt_reg + 1'b1;
    end
    // The first stable value after reset is always taken, even when it equals f
    take = s_valid && (cnt_next == CW'(FILT_CYCLES)) &&
           ((cand_next != f_reg) || !primed_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg   <= '0;
      valid_reg  <= '0;
      cand_reg   <= PH_00;
      cnt_reg    <= '0;
      f_reg      <= PH_00;
      primed_reg <= 1'b0;
      accept_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[2*SYNC_STAGES-3:0], enc_a, enc_b};
      valid_reg  <= {valid_reg[SYNC_STAGES-2:0], 1'b1};
      accept_reg <= take;
      if (s_valid) begin
        cand_reg <= cand_next;
        cnt_reg  <= cnt_next;
      end
      if (take) begin
        f_reg      <= cand_next;
        primed_reg <= 1'b1;
      end
    end
  end

  assign f      = f_reg;
  assign accept = accept_reg;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature command stage: filtered Gray phases in, step/direction pulses out,
// with a sticky flag for transitions that skip a Gray state.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int X1_MODE     = 0
) (
  input logic                clk,
  input logic                rst,
  quad_step_decoder_if.slave bus
);

  phase_t      f_pair;
  logic        accept;
  qdec_state_t state_reg, state_next;
  phase_t      base_reg, base_next;
  logic        step_reg, step_next;
  logic        up_down_reg, up_down_next;
  logic        err_reg, err_next;
  logic        illegal;
  logic        fwd, bwd, emit;

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .enc_a  (bus.enc_a),
    .enc_b  (bus.enc_b),
    .f      (f_pair),
    .accept (accept)
  );

  assign fwd  = (gray_next(base_reg) == f_pair);
  assign bwd  = (gray_next(f_pair) == base_reg);
  // x1 counts one step per cycle, on entry to 00 from either neighbour
  assign emit = (X1_MODE == 0) || (f_pair == PH_00);

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    step_next    = 1'b0;
    up_down_next = up_down_reg;
    err_next     = err_reg;
    illegal      = 1'b0;
    if (accept) begin
      base_next = f_pair;
      case (state_reg)
        INIT: state_next = TRACK;
        TRACK: begin
          if (fwd) begin
            if (emit) begin
              step_next    = 1'b1;
              up_down_next = DIR_UP;
            end
          end else if (bwd) begin
            if (emit) begin
              step_next    = 1'b1;
              up_down_next = DIR_DN;
            end
          end else if (f_pair != base_reg) begin
            illegal = 1'b1;
          end
        end
        default: state_next = INIT;
      endcase
    end
    // A coincident illegal transition wins over the clear request
    if (illegal) begin
      err_next = 1'b1;
    end else if (bus.err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= INIT;
      base_reg    <= PH_00;
      step_reg    <= 1'b0;
      up_down_reg <= DIR_UP;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      step_reg    <= step_next;
      up_down_reg <= up_down_next;
      err_reg     <= err_next;
    end
  end

  assign bus.step    = step_reg;
  assign bus.up_down = up_down_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: an x4 and an x1 decoder share the same encoder stimulus;
// expected step pulses are queued per instance and matched as they appear.
module tb_quad_step_decoder;
  import qdec_pkg::*;

  typedef struct {
    int   cyc;
    logic dir;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4;
  exp_t e1;

  quad_step_decoder_if bus4 ();
  quad_step_decoder_if bus1 ();

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .X1_MODE(0)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  quad_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .X1_MODE(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Step monitors: every pulse must match the head of its queue in cycle and direction
  always @(negedge clk) begin
    if (bus4.step === 1'b1) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL x4_unexpected_step cyc=%0d dir=%0b required no step", cyc, bus4.up_down);
      end else begin
        e4 = q4.pop_front();
        if (cyc !== e4.cyc || bus4.up_down !== e4.dir) begin
          n_fail++;
          $display("FAIL x4_step got cyc=%0d dir=%0b required cyc=%0d dir=%0b",
                   cyc, bus4.up_down, e4.cyc, e4.dir);
        end else begin
          $display("x4 step cyc=%0d dir=%0b ok", cyc, bus4.up_down);
        end
      end
    end
    if (bus1.step === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL x1_unexpected_step cyc=%0d dir=%0b required no step", cyc, bus1.up_down);
      end else begin
        e1 = q1.pop_front();
        if (cyc !== e1.cyc || bus1.up_down !== e1.dir) begin
          n_fail++;
          $display("FAIL x1_step got cyc=%0d dir=%0b required cyc=%0d dir=%0b",
                   cyc, bus1.up_down, e1.cyc, e1.dir);
        end else begin
          $display("x1 step cyc=%0d dir=%0b ok", cyc, bus1.up_down);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_enc(input logic [1:0] ab);
    bus4.enc_a = ab[1];
    bus4.enc_b = ab[0];
    bus1.enc_a = ab[1];
    bus1.enc_b = ab[0];
  endtask

  task automatic set_clr(input logic v);
    bus4.err_clr = v;
    bus1.err_clr = v;
  endtask

  task automatic push4(input int c, input logic d);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    q4.push_back(e);
  endtask

  task automatic push1(input int c, input logic d);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    q1.push_back(e);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    rst = 1'b1;
    set_enc(ab);
    set_clr(1'b0);
    tick(2);
    rst = 1'b0;
    tick(12);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_enc(2'b11);
    set_clr(1'b0);
    tick(3);
    n_cmp++;
    if ({bus4.step, bus4.up_down, bus4.err, bus1.step, bus1.up_down, bus1.err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got x4=%b%b%b x1=%b%b%b required 000/000",
               bus4.step, bus4.up_down, bus4.err, bus1.step, bus1.up_down, bus1.err);
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      n_cmp++;
      if (bus4.err !== 1'b0 || bus1.err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_err cyc=%0d got %b/%b required 0/0", cyc, bus4.err, bus1.err);
      end
      if (i == 5) begin
        n_cmp++;
        if (dut4.state_reg !== INIT) begin
          n_fail++;
          $display("FAIL reset_state_early got %0d required INIT", dut4.state_reg);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (dut4.state_reg !== TRACK || dut1.state_reg !== TRACK) begin
          n_fail++;
          $display("FAIL reset_state_track got %0d/%0d required TRACK", dut4.state_reg, dut1.state_reg);
        end
      end
    end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (q4.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_steps got pending x4=%0d x1=%0d required 0/0", name, q4.size(), q1.size());
      q4.delete();
      q1.delete();
    end
  endtask

  task automatic test_forward;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      set_enc(seq[i]);
      push4(cyc + 7, DIR_UP);
      if (i == 3) push1(cyc + 7, DIR_UP);
      tick(10);
    end
    tick(2);
    check_drained("forward");
  endtask

  task automatic test_reverse;
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      set_enc(seq[i]);
      push4(cyc + 7, DIR_DN);
      if (i == 3) push1(cyc + 7, DIR_DN);
      tick(10);
    end
    tick(2);
    check_drained("reverse");
  endtask

  task automatic test_glitch;
    // Short pulse on A never reaches f
    set_enc(2'b10);
    tick(3);
    set_enc(2'b00);
    tick(15);
    n_cmp++;
    if (dut4.f_pair !== PH_00 || dut1.f_pair !== PH_00 || bus4.err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_short got f=%b/%b err=%b required f=00/00 err=0",
               dut4.f_pair, dut1.f_pair, bus4.err);
    end
    check_drained("glitch_short");
    // Four-cycle pulse on A: 00->10 (down) then 10->00 (up)
    set_enc(2'b10);
    push4(cyc + 7, DIR_DN);
    tick(4);
    set_enc(2'b00);
    push4(cyc + 7, DIR_UP);
    push1(cyc + 7, DIR_UP);
    tick(15);
    // Four-cycle pulse on B: 00->01 (up) then 01->00 (down)
    set_enc(2'b01);
    push4(cyc + 7, DIR_UP);
    tick(4);
    set_enc(2'b00);
    push4(cyc + 7, DIR_DN);
    push1(cyc + 7, DIR_DN);
    tick(15);
    n_cmp++;
    if (bus4.err !== 1'b0 || bus1.err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_err got %b/%b required 0/0", bus4.err, bus1.err);
    end
    check_drained("glitch_long");
  endtask

  task automatic test_illegal;
    set_enc(2'b11);
    tick(6);
    n_cmp++;
    if (bus4.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_early got err=%b required 0", bus4.err);
    end
    tick(3);
    n_cmp++;
    if (bus4.err !== 1'b1 || bus1.err !== 1'b1 || dut4.f_pair !== PH_11) begin
      n_fail++;
      $display("FAIL illegal_set got err=%b/%b f=%b required err=1/1 f=11",
               bus4.err, bus1.err, dut4.f_pair);
    end
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    n_cmp++;
    if (bus4.err !== 1'b0 || bus1.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b/%b required 0/0", bus4.err, bus1.err);
    end
    // 11->00 whose decode edge coincides with err_clr
    set_enc(2'b00);
    tick(6);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    n_cmp++;
    if (bus4.err !== 1'b1 || bus1.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clr_collision got %b/%b required 1/1", bus4.err, bus1.err);
    end
    tick(3);
    n_cmp++;
    if (bus4.err !== 1'b1 || dut4.f_pair !== PH_00) begin
      n_fail++;
      $display("FAIL err_sticky got err=%b f=%b required err=1 f=00", bus4.err, dut4.f_pair);
    end
    check_drained("illegal");
  endtask

  task automatic test_reset_mid;
    do_reset(2'b00);
    n_cmp++;
    if (bus4.err !== 1'b0 || bus1.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_err got %b/%b required 0/0", bus4.err, bus1.err);
    end
    set_enc(2'b01);
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_cmp++;
    if ({bus4.step, bus4.up_down, bus4.err, bus1.step, bus1.up_down, bus1.err} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got x4=%b%b%b x1=%b%b%b required 000/000",
               bus4.step, bus4.up_down, bus4.err, bus1.step, bus1.up_down, bus1.err);
    end
    tick(4);
    n_cmp++;
    if (dut4.state_reg !== INIT) begin
      n_fail++;
      $display("FAIL mid_reset_init got %0d required INIT", dut4.state_reg);
    end
    tick(6);
    n_cmp++;
    if (dut4.state_reg !== TRACK || dut4.f_pair !== PH_01 || dut1.f_pair !== PH_01) begin
      n_fail++;
      $display("FAIL mid_reset_baseline got state=%0d f=%b/%b required TRACK f=01/01",
               dut4.state_reg, dut4.f_pair, dut1.f_pair);
    end
    set_enc(2'b11);
    push4(cyc + 7, DIR_UP);
    tick(10);
    check_drained("reset_mid");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    set_enc(2'b00);
    set_clr(1'b0);
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
